wb_write_ctrl: RTL and testbench
================================

# wb_write_ctrl

Writeback controller that drives the write side of the 16×16 register file. It accepts results from two producers (ALU, memory) over valid/ready handshakes and orders them through a small FIFO. It issues at most one registered write per cycle on the register file's write-enable/address/data port, and keeps a per-register pending-write scoreboard for the issue stage.

## Interface
- DATA_W, 16, result/register width
- ADDR_W, 4, register address width (2^ADDR_W registers)
- DEPTH, 4, FIFO entries (2..6)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s0_valid, s1_valid  in  1  source result valid (s0 = ALU, s1 = memory)
- s0_ready, s1_ready  out  1  source may hand over this cycle
- s0_addr, s1_addr  in  ADDR_W  destination register
- s0_data, s1_data  in  DATA_W  result value
- rf_hold  in  1  register file cannot take a write this cycle
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  ADDR_W  write address (registered)
- wr_data  out  DATA_W  write data (registered)
- busy_vec  out  2^ADDR_W  bit r = write to r pending (FIFO or output stage)
- q_addr  in  ADDR_W  forwarding query address
- q_hit  out  1  query register has a pending value
- q_data  out  DATA_W  youngest pending value for q_addr

## Operation
- Transfer on sK_valid & sK_ready at a rising edge; entry pushed to FIFO at that edge.
- Ready rules, free = DEPTH − occupancy (occupancy counted before this cycle's pop):
  - free ≥ 2: both ready.
  - free == 1: only one ready. Ready goes to the rr-favored source if it is valid; otherwise to the other source.
  - free == 0 or reset high: both low.
- 1-bit round-robin pointer rr, reset 0 (favors s0):
  - Both accepted in one cycle: push rr-favored entry first (older).
  - rr flips whenever both sources were valid in the same cycle.
- Pop: FIFO non-empty & !rf_hold → head loads wr_en=1/wr_addr/wr_data at the edge. Otherwise wr_en=0 at the edge; wr_addr/wr_data hold.
- Push and pop are allowed in the same cycle. The 2-push + 1-pop net-change case must be handled.
- Scoreboard: per-register counter, width $clog2(DEPTH+2).
  - +1 per push to that address, two pushes to the same address add 2.
  - −1 when wr_en=1 for that address at an edge, i.e. when the write commits in the register file.
  - busy_vec[r] = (cnt[r] != 0).
- Same-address writes commit in FIFO order; the last committed value wins.

## Timing
- Accept at edge E → earliest wr_en high in cycle after E+1 → register file captures at E+2. Latency 2 edges with empty FIFO and rf_hold low.
- Throughput: one write/cycle sustained. Bursts of 2/cycle are absorbed up to DEPTH.
- ready and q_* are combinational. All other outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy_vec=0, q_hit=0, q_data=0, FIFO empty, rr=0.
- Reset mid-operation discards all FIFO entries and the in-flight output. No write is issued in the cycle after reset.

## Configuration
- WB_FWD_EN defined: q_hit/q_data search the output stage (only when wr_en=1) plus all valid FIFO entries. Youngest match wins; q_hit=0, q_data=0 on a miss.
- WB_FWD_EN undefined: q_hit=0 and q_data=0 constantly, with no search logic. busy_vec remains available for stalling.

## Structure
- Shared package wb_pkg: DATA_W/ADDR_W defaults, NUM_REGS = 2^ADDR_W, and a wb_entry_t struct {addr, data}.
- One sub-module: wb_fifo, a DEPTH-entry ring with 0–2 pushes and 0–1 pop per cycle, exposing occupancy and the entry array for forwarding.
- Arbitration, scoreboard and output register live in wb_write_ctrl.

## Test plan
- Single s0 write addr 3, data 0xBEEF, rf_hold=0 → wr_en=1, wr_addr=3, wr_data=0xBEEF two edges later. busy_vec[3] = 1 until that commit edge, then 0.
- Both valid every cycle, addresses 1/2, for 8 cycles → FIFO fills and ready throttles as specified. Writes alternate in rr order with no loss and no duplication. busy_vec returns to 0 after drain.
- Same cycle, s0 and s1 both target addr 5, data 0x1111/0x2222, rr=0 → commits 0x1111 then 0x2222. cnt[5] peaks at 2.
- rf_hold high for 5 cycles with 4 queued entries → wr_en=0, both ready=0 once full. After release, 4 consecutive writes in order.
- WB_FWD_EN: two queued writes to addr 7 (0x00AA, then 0x00BB), q_addr=7 → q_hit=1, q_data=0x00BB. After both commit → q_hit=0. Without the macro → q_hit=0 throughout.
- Reset asserted with 3 entries queued and wr_en=1 → next cycle wr_en=0, busy_vec=0. Both ready=0 while reset is high, and =1 the first cycle after.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register count and FIFO entry type for the writeback controller
//   DATA_W   result/register width
//   ADDR_W   register address width
//   NUM_REGS number of architectural registers (2^ADDR_W)
//   wb_entry_t  one pending register-file write {addr, data}
package wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_ctrl_if.sv
// wb_write_ctrl_if: producer handshakes, register-file write port, scoreboard and forwarding query
//   s0_*/s1_*  ALU / memory result handshakes (valid, ready, addr, data)
//   rf_hold    register file cannot take a write this cycle
//   wr_*       registered register-file write port
//   busy_vec   per-register pending-write flags
//   q_addr/q_hit/q_data  forwarding query
//   modport master: producers, register file and issue stage side
//   modport slave:  the writeback controller
interface wb_write_ctrl_if;

    import wb_pkg::*;

    logic                s0_valid;
    logic                s0_ready;
    logic [ADDR_W-1:0]   s0_addr;
    logic [DATA_W-1:0]   s0_data;
    logic                s1_valid;
    logic                s1_ready;
    logic [ADDR_W-1:0]   s1_addr;
    logic [DATA_W-1:0]   s1_data;
    logic                rf_hold;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] busy_vec;
    logic [ADDR_W-1:0]   q_addr;
    logic                q_hit;
    logic [DATA_W-1:0]   q_data;

    modport master (
        output s0_valid, s0_addr, s0_data,
        output s1_valid, s1_addr, s1_data,
        output rf_hold, q_addr,
        input  s0_ready, s1_ready,
        input  wr_en, wr_addr, wr_data,
        input  busy_vec, q_hit, q_data
    );

    modport slave (
        input  s0_valid, s0_addr, s0_data,
        input  s1_valid, s1_addr, s1_data,
        input  rf_hold, q_addr,
        output s0_ready, s1_ready,
        output wr_en, wr_addr, wr_data,
        output busy_vec, q_hit, q_data
    );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry ring taking 0-2 pushes and 0-1 pop per cycle
//   clk, reset  clock, synchronous active-high reset (empties the ring)
//   push_n      number of entries pushed this cycle (0..2); in0 is older than in1
//   in0, in1    entries to push
//   pop         remove the head this cycle (caller guarantees non-empty)
//   head        oldest entry
//   count       occupancy before this cycle's push/pop
//   ordered     (WB_FWD_EN only) entries oldest-first, valid below count
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   push_n,
    input  wb_entry_t                    in0,
    input  wb_entry_t                    in1,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef WB_FWD_EN
    ,
    output wb_entry_t                    ordered [DEPTH]
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr1;
    logic [PW-1:0]   wr_ptr2;

    // DEPTH need not be a power of two, so pointers wrap explicitly
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_ptr1 = nxt(wr_ptr);
    assign wr_ptr2 = nxt(wr_ptr1);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_n != 2'd0)
            mem[wr_ptr] <= in0;
        if (push_n == 2'd2)
            mem[wr_ptr1] <= in1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= (push_n == 2'd2) ? wr_ptr2 : (push_n == 2'd1) ? wr_ptr1 : wr_ptr;
            rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
            count  <= count + CW'(push_n) - CW'(pop);
        end
    end

`ifdef WB_FWD_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ordered[i] = mem[PW'((int'(rd_ptr) + i) % DEPTH)];
    end
`endif

endmodule

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: writeback controller arbitrating ALU/memory results into the register-file write port
//   clk, reset  clock, synchronous active-high reset
//   bus         wb_write_ctrl_if.slave: s0/s1 valid/ready handshakes, rf_hold,
//               registered wr_en/wr_addr/wr_data, busy_vec scoreboard, q_* forwarding query
//   DEPTH       FIFO entries (2..6)
//   Define WB_FWD_EN to enable the q_hit/q_data forwarding search; otherwise q_* are tied to 0.
module wb_write_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    wb_write_ctrl_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + 2);

    logic [CW-1:0]       occ;
    logic [CW-1:0]       free;
    logic                wide;
    logic                one;
    logic                r0;
    logic                r1;
    logic                acc0;
    logic                acc1;
    logic                pop;
    logic [1:0]          push_n;
    wb_entry_t           e0;
    wb_entry_t           e1;
    wb_entry_t           in0;
    wb_entry_t           in1;
    wb_entry_t           head;
    logic                rr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [SW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;
    logic                q_hit;
    logic [DATA_W-1:0]   q_data;

    // free space is taken before this cycle's pop, so a full FIFO never accepts
    assign free = CW'(DEPTH) - occ;
    assign wide = free >= CW'(2);
    assign one  = free == CW'(1);

    // with a single free slot the favoured source gets it if valid, else the other one
    assign r0 = !reset && (wide || (one && (rr ? !bus.s1_valid : bus.s0_valid)));
    assign r1 = !reset && (wide || (one && (rr ? bus.s1_valid : !bus.s0_valid)));

    assign acc0   = bus.s0_valid && r0;
    assign acc1   = bus.s1_valid && r1;
    assign push_n = {1'b0, acc0} + {1'b0, acc1};
    assign pop    = (occ != '0) && !bus.rf_hold;

    assign e0 = '{addr: bus.s0_addr, data: bus.s0_data};
    assign e1 = '{addr: bus.s1_addr, data: bus.s1_data};

    // in0 is the older slot: on a double accept it takes the rr-favoured source
    assign in0 = (acc0 && acc1) ? (rr ? e1 : e0) : (acc0 ? e0 : e1);
    assign in1 = rr ? e0 : e1;

`ifdef WB_FWD_EN
    wb_entry_t ordered [DEPTH];
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_n  (push_n),
        .in0     (in0),
        .in1     (in1),
        .pop     (pop),
        .head    (head),
        .count   (occ)
`ifdef WB_FWD_EN
        ,
        .ordered (ordered)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rr      <= 1'b0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_addr <= head.addr;
                wr_data <= head.data;
            end
            if (bus.s0_valid && bus.s1_valid)
                rr <= !rr;
        end
    end

    // counts every pending write to a register until it commits on the write port
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset)
                cnt[r] <= '0;
            else
                cnt[r] <= cnt[r]
                        + SW'(acc0 && (bus.s0_addr == ADDR_W'(r)))
                        + SW'(acc1 && (bus.s1_addr == ADDR_W'(r)))
                        - SW'(wr_en && (wr_addr == ADDR_W'(r)));
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++)
            busy_vec[r] = cnt[r] != '0;
    end

`ifdef WB_FWD_EN
    // oldest first, so later (younger) matches override earlier ones
    always_comb begin
        q_hit  = wr_en && (wr_addr == bus.q_addr);
        q_data = q_hit ? wr_data : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < occ) && (ordered[i].addr == bus.q_addr)) begin
                q_hit  = 1'b1;
                q_data = ordered[i].data;
            end
        end
    end
`else
    assign q_hit  = 1'b0;
    assign q_data = '0;
`endif

    assign bus.s0_ready = r0;
    assign bus.s1_ready = r1;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.busy_vec = busy_vec;
    assign bus.q_hit    = q_hit;
    assign bus.q_data   = q_data;

endmodule

// File: tb/tb_wb_write_ctrl.sv
// tb_wb_write_ctrl: directed bench for wb_write_ctrl with a queue-based reference model
module tb_wb_write_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   pass_n = 0;
    int   total_n = 0;
    bit   chk_on = 1'b0;
    int   commits [16];

    wb_write_ctrl_if bus ();

    wb_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model: pending writes as a queue, output stage, per-register counts
    ent_t        mq [$];
    int          mcnt [16];
    bit          m_en;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    bit          m_rr;

    function automatic void m_ready(output bit r0, output bit r1);
        int free;
        free = DEPTH - mq.size();
        r0 = 1'b0;
        r1 = 1'b0;
        if (reset)
            return;
        if (free >= 2) begin
            r0 = 1'b1;
            r1 = 1'b1;
        end else if (free == 1) begin
            if (m_rr ? bus.s1_valid : bus.s0_valid) begin
                r0 = !m_rr;
                r1 = m_rr;
            end else begin
                r0 = m_rr;
                r1 = !m_rr;
            end
        end
    endfunction

    function automatic void m_fwd(output bit h, output logic [15:0] d);
        h = 1'b0;
        d = '0;
`ifdef WB_FWD_EN
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == bus.q_addr) begin
                h = 1'b1;
                d = mq[i].d;
                return;
            end
        end
        if (m_en && m_addr == bus.q_addr) begin
            h = 1'b1;
            d = m_data;
        end
`endif
    endfunction

    always @(posedge clk) begin
        bit   r0, r1, a0, a1;
        ent_t e0, e1, h;
        if (reset) begin
            mq.delete();
            foreach (mcnt[i]) mcnt[i] = 0;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_rr   = 1'b0;
        end else begin
            m_ready(r0, r1);
            a0 = bus.s0_valid && r0;
            a1 = bus.s1_valid && r1;
            if (m_en)
                mcnt[m_addr]--;
            if (mq.size() > 0 && !bus.rf_hold) begin
                h      = mq.pop_front();
                m_en   = 1'b1;
                m_addr = h.a;
                m_data = h.d;
            end else begin
                m_en = 1'b0;
            end
            e0 = '{bus.s0_addr, bus.s0_data};
            e1 = '{bus.s1_addr, bus.s1_data};
            if (a0 && a1) begin
                if (m_rr) begin
                    mq.push_back(e1);
                    mq.push_back(e0);
                end else begin
                    mq.push_back(e0);
                    mq.push_back(e1);
                end
            end else if (a0) begin
                mq.push_back(e0);
            end else if (a1) begin
                mq.push_back(e1);
            end
            if (a0) mcnt[e0.a]++;
            if (a1) mcnt[e1.a]++;
            if (bus.s0_valid && bus.s1_valid)
                m_rr = !m_rr;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp)
            pass_n++;
        else
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    // one compare process: every cycle, mid-period, against the model
    always @(negedge clk) begin
        bit          r0, r1, h;
        logic [15:0] d;
        logic [15:0] busy;
        if (chk_on) begin
            m_ready(r0, r1);
            m_fwd(h, d);
            busy = '0;
            foreach (mcnt[i]) busy[i] = mcnt[i] != 0;
            chk("wr_en", bus.wr_en, m_en);
            chk("wr_addr", bus.wr_addr, m_addr);
            chk("wr_data", bus.wr_data, m_data);
            chk("busy_vec", bus.busy_vec, busy);
            chk("s0_ready", bus.s0_ready, r0);
            chk("s1_ready", bus.s1_ready, r1);
            chk("q_hit", bus.q_hit, h);
            chk("q_data", bus.q_data, d);
            if (bus.wr_en === 1'b1)
                commits[bus.wr_addr]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v0, input logic [3:0] a0, input logic [15:0] d0,
                         input bit v1, input logic [3:0] a1, input logic [15:0] d1);
        bus.s0_valid = v0;
        bus.s0_addr  = a0;
        bus.s0_data  = d0;
        bus.s1_valid = v1;
        bus.s1_addr  = a1;
        bus.s1_data  = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          n0, n1, b1, b2;
        logic [15:0] d0, d1;
        logic [15:0] hold_exp [4];
        bit          exp_hit;
        logic [15:0] exp_q;
        foreach (commits[i]) commits[i] = 0;
        reset       = 1'b1;
        bus.rf_hold = 1'b0;
        bus.q_addr  = '0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_on = 1'b1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_busy", bus.busy_vec, 0);
        chk("rst_q_hit", bus.q_hit, 0);
        step();
        reset = 1'b0;

        // single write, latency two edges
        drive(1, 3, 16'hBEEF, 0, 0, 0);
        #1 chk("t1_s0_ready", bus.s0_ready, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_busy3_a", bus.busy_vec[3], 1);
        chk("t1_wr_en_a", bus.wr_en, 0);
        step();
        chk("t1_wr_en_b", bus.wr_en, 1);
        chk("t1_wr_addr", bus.wr_addr, 3);
        chk("t1_wr_data", bus.wr_data, 16'hBEEF);
        chk("t1_busy3_b", bus.busy_vec[3], 1);
        step();
        chk("t1_wr_en_c", bus.wr_en, 0);
        chk("t1_busy_c", bus.busy_vec, 0);

        // both sources valid for 8 cycles
        b1 = commits[1];
        b2 = commits[2];
        n0 = 0;
        n1 = 0;
        d0 = 16'h1000;
        d1 = 16'h2000;
        for (int c = 0; c < 8; c++) begin
            bit a0, a1;
            drive(1, 1, d0, 1, 2, d1);
            #1;
            a0 = bus.s0_ready;
            a1 = bus.s1_ready;
            step();
            if (a0) begin d0++; n0++; end
            if (a1) begin d1++; n1++; end
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20 && bus.busy_vec != 0; k++)
            step();
        step();
        chk("t2_acc_s0", n0, 5);
        chk("t2_acc_s1", n1, 5);
        chk("t2_commits_1", commits[1] - b1, 5);
        chk("t2_commits_2", commits[2] - b2, 5);
        chk("t2_busy_drained", bus.busy_vec, 0);

        // same address from both sources, rr favours s0
        drive(1, 5, 16'h1111, 1, 5, 16'h2222);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_cnt5_peak", mcnt[5], 2);
        chk("t3_busy5", bus.busy_vec[5], 1);
        step();
        chk("t3_first", bus.wr_data, 16'h1111);
        step();
        chk("t3_second", bus.wr_data, 16'h2222);
        chk("t3_second_en", bus.wr_en, 1);
        step();
        chk("t3_done_en", bus.wr_en, 0);
        chk("t3_done_busy", bus.busy_vec, 0);

        // rf_hold with a full FIFO; rr now favours s1
        bus.rf_hold = 1'b1;
        drive(1, 8, 16'h00A0, 1, 9, 16'h00A1);
        step();
        drive(1, 10, 16'h00A2, 1, 11, 16'h00A3);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t4_full_r0", bus.s0_ready, 0);
        chk("t4_full_r1", bus.s1_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_en", bus.wr_en, 0);
        end
        bus.rf_hold = 1'b0;
        hold_exp[0] = 16'h00A1;
        hold_exp[1] = 16'h00A0;
        hold_exp[2] = 16'h00A2;
        hold_exp[3] = 16'h00A3;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_release_en", bus.wr_en, 1);
            chk("t4_release_data", bus.wr_data, hold_exp[k]);
        end
        step();
        chk("t4_idle_en", bus.wr_en, 0);

        // forwarding of two queued writes to addr 7
`ifdef WB_FWD_EN
        exp_hit = 1'b1;
        exp_q   = 16'h00BB;
`else
        exp_hit = 1'b0;
        exp_q   = 16'h0000;
`endif
        bus.rf_hold = 1'b1;
        drive(1, 7, 16'h00AA, 0, 0, 0);
        step();
        drive(1, 7, 16'h00BB, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        bus.q_addr = 7;
        #1;
        chk("t5_q_hit", bus.q_hit, exp_hit);
        chk("t5_q_data", bus.q_data, exp_q);
        bus.rf_hold = 1'b0;
        step();
        step();
        step();
        chk("t5_q_hit_after", bus.q_hit, 0);
        chk("t5_busy_after", bus.busy_vec, 0);

        // reset with three queued entries and a write in flight
        drive(1, 1, 16'h0C01, 1, 2, 16'h0C02);
        step();
        drive(1, 3, 16'h0C03, 1, 4, 16'h0C04);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_wr_en", bus.wr_en, 1);
        chk("t6_queued", mq.size(), 3);
        reset = 1'b1;
        #1;
        chk("t6_rst_r0", bus.s0_ready, 0);
        chk("t6_rst_r1", bus.s1_ready, 0);
        step();
        chk("t6_rst_wr_en", bus.wr_en, 0);
        chk("t6_rst_busy", bus.busy_vec, 0);
        reset = 1'b0;
        #1;
        chk("t6_post_r0", bus.s0_ready, 1);
        chk("t6_post_r1", bus.s1_ready, 1);
        step();
        chk("t6_post_wr_en", bus.wr_en, 0);
        step();

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
